icache_dm: RTL and testbench

Direct-mapped instruction cache between the fetch stage (PC generator, reset PC 0x0000_1000) and the instruction memory port. It serves 32-bit instructions from 4 lines of 128 bits each. Hits respond in the same cycle. A miss stalls fetch, refills one whole line over a valid/ready memory handshake, and forwards the requested word.

---
 rtl/icache_dm.sv | 163 ++++++++++++++++
 tb/tb_icache_dm.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: same-cycle hits, single-line refill over valid/ready, forwarded miss word.
// Optional hit/miss counters are enabled with `define ICACHE_PERF_EN.
module icache_dm #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned INST_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  input  logic [ADDR_W-1:0]    req_addr_i,
  output logic                 resp_valid_o,
  output logic [INST_W-1:0]    resp_instr_o,
  output logic                 stall_o,
  input  logic                 invalidate_i,
  output logic                 mem_req_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  input  logic                 mem_ready_i,
  input  logic [LINE_BITS-1:0] mem_rdata_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]          hit_count_o,
  output logic [31:0]          miss_count_o
`endif
);
  localparam int unsigned OFF_W  = $clog2(LINE_BITS / 8);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned BOFF   = $clog2(INST_W / 8);
  localparam int unsigned WSEL_W = $clog2(LINE_BITS / INST_W);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

  state_t                 state_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0]   data_q [NUM_LINES];
  logic [IDX_W-1:0]       idx_q;
  logic [TAG_W-1:0]       ctag_q;
  logic [WSEL_W-1:0]      wsel_q;
  logic                   mem_req_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic                   inv_pend_q;
  logic                   abandon_q;
  logic [INST_W-1:0]      last_q;

  logic [IDX_W-1:0]       req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [WSEL_W-1:0]      req_wsel;
  logic                   hit;
  logic [INST_W-1:0]      hit_word;
  logic [INST_W-1:0]      fill_word;
  logic                   unused_bits;

  assign req_idx     = req_addr_i[OFF_W +: IDX_W];
  assign req_tag     = req_addr_i[ADDR_W-1 -: TAG_W];
  assign req_wsel    = req_addr_i[BOFF +: WSEL_W];
  assign unused_bits = ^req_addr_i[BOFF-1:0];
  assign hit         = req_valid_i && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_word    = data_q[req_idx][req_wsel*INST_W +: INST_W];
  assign fill_word   = data_q[idx_q][wsel_q*INST_W +: INST_W];

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;

  // Outputs are forced quiet while reset is held so a pending request cannot raise stall.
  always_comb begin
    resp_valid_o = 1'b0;
    resp_instr_o = last_q;
    stall_o      = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            resp_valid_o = 1'b1;
            resp_instr_o = hit_word;
          end else if (req_valid_i) begin
            stall_o = 1'b1;
          end
        end
        MISS: stall_o = 1'b1;
        FILL: begin
          if (req_valid_i && !abandon_q) begin
            resp_valid_o = 1'b1;
            resp_instr_o = fill_word;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      idx_q      <= '0;
      ctag_q     <= '0;
      wsel_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      inv_pend_q <= 1'b0;
      abandon_q  <= 1'b0;
      last_q     <= '0;
    end else begin
      if (resp_valid_o) last_q <= resp_instr_o;
      case (state_q)
        IDLE: begin
          if (invalidate_i) valid_q <= '0;
          if (req_valid_i && !hit) begin
            state_q    <= MISS;
            idx_q      <= req_idx;
            ctag_q     <= req_tag;
            wsel_q     <= req_wsel;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            abandon_q  <= 1'b0;
            inv_pend_q <= 1'b0;
          end
        end
        MISS: begin
          if (!req_valid_i) abandon_q <= 1'b1;
          if (invalidate_i) begin
            valid_q    <= '0;
            inv_pend_q <= 1'b1;
          end
          // The indexed write follows the flash clear so the refilled line's bit wins.
          if (mem_ready_i) begin
            state_q          <= FILL;
            mem_req_q        <= 1'b0;
            valid_q[idx_q]   <= !(inv_pend_q || invalidate_i);
          end
        end
        FILL: begin
          if (invalidate_i) valid_q <= '0;
          inv_pend_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == MISS && mem_ready_i) begin
      data_q[idx_q] <= mem_rdata_i;
      tag_q[idx_q]  <= ctag_q;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (state_q == IDLE) begin
      if (hit && hit_count_o != '1) hit_count_o <= hit_count_o + 32'd1;
      if (req_valid_i && !hit && miss_count_o != '1) miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: transaction-level cache model, directed scenarios, then random traffic.
module tb_icache_dm;
  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_i;
  logic [19:0]   req_addr_i;
  logic          resp_valid_o;
  logic [31:0]   resp_instr_o;
  logic          stall_o;
  logic          invalidate_i;
  logic          mem_req_o;
  logic [19:0]   mem_addr_o;
  logic          mem_ready_i;
  logic [127:0]  mem_rdata_i;
`ifdef ICACHE_PERF_EN
  logic [31:0]   hit_count_o, miss_count_o;
`endif

  icache_dm #(.NUM_LINES(4), .LINE_BITS(128), .ADDR_W(20), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .resp_valid_o(resp_valid_o), .resp_instr_o(resp_instr_o), .stall_o(stall_o),
    .invalidate_i(invalidate_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
`ifdef ICACHE_PERF_EN
    , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned tests = 0, errs = 0;

  // Model: cache contents per index plus the outstanding-miss record.
  bit           mv [4];
  logic [13:0]  mt [4];
  logic [127:0] md [4];
  int           ph;          // 0 = lookup, 1 = awaiting refill, 2 = delivering refilled word
  logic [19:0]  maddr;
  bit           mab, mpend;
  logic [127:0] mfill;
  logic [31:0]  mlast;
  int unsigned  mhits, mmiss;
  logic [127:0] mem [logic [19:0]];

  logic         a_rv, a_st, a_mr;
  logic [31:0]  a_in;
  logic [19:0]  a_ma;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] line_of(input logic [19:0] a);
    return {a[19:4], 4'h0};
  endfunction

  function automatic logic [127:0] get_line(input logic [19:0] l);
    if (!mem.exists(l)) mem[l] = {$urandom, $urandom, $urandom, $urandom};
    return mem[l];
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] l, input int w);
    return l[w*32 +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    ph = 0; mlast = '0; mhits = 0; mmiss = 0; mab = 0; mpend = 0;
  endtask

  task automatic cycle(input bit rv, input logic [19:0] ra, input bit inv, input bit rdy);
    logic [127:0] rd;
    bit           hit, e_rv, e_st, e_mr;
    logic [31:0]  e_in;
    int           ix, w;
    req_valid_i = rv; req_addr_i = ra; invalidate_i = inv; mem_ready_i = rdy;
    rd = (ph == 1) ? get_line(line_of(maddr)) : {$urandom, $urandom, $urandom, $urandom};
    mem_rdata_i = rd;
    ix = int'(ra[5:4]); w = int'(ra[3:2]);
    hit = 0; e_rv = 0; e_st = 0; e_mr = 0; e_in = mlast;
    case (ph)
      0: begin
        hit = rv && mv[ix] && (mt[ix] == ra[19:6]);
        if (hit) begin e_rv = 1; e_in = word_of(md[ix], w); end
        e_st = rv && !hit;
      end
      1: begin e_st = 1; e_mr = 1; end
      default: if (rv && !mab) begin e_rv = 1; e_in = word_of(mfill, int'(maddr[3:2])); end
    endcase
    #4;
    a_rv = resp_valid_o; a_in = resp_instr_o; a_st = stall_o; a_mr = mem_req_o; a_ma = mem_addr_o;
    chk("resp_valid", {31'b0, a_rv}, {31'b0, e_rv});
    chk("resp_instr", a_in, e_in);
    chk("stall", {31'b0, a_st}, {31'b0, e_st});
    chk("mem_req", {31'b0, a_mr}, {31'b0, e_mr});
    if (e_mr) chk("mem_addr", {12'b0, a_ma}, {12'b0, line_of(maddr)});
`ifdef ICACHE_PERF_EN
    chk("hit_count", hit_count_o, mhits);
    chk("miss_count", miss_count_o, mmiss);
`endif
    @(posedge clk);
    case (ph)
      0: begin
        if (hit) mhits++;
        if (inv) for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        if (rv && !hit) begin ph = 1; maddr = ra; mab = 0; mpend = 0; mmiss++; end
      end
      1: begin
        if (!rv) mab = 1;
        if (inv) begin for (int i = 0; i < 4; i++) mv[i] = 1'b0; mpend = 1; end
        if (rdy) begin
          md[int'(maddr[5:4])] = rd; mt[int'(maddr[5:4])] = maddr[19:6];
          mv[int'(maddr[5:4])] = !mpend; mfill = rd; ph = 2;
        end
      end
      default: begin
        if (inv) for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        ph = 0;
      end
    endcase
    if (e_rv) mlast = e_in;
    @(negedge clk);
  endtask

  // Miss cycle, one refill cycle with ready, then the delivery cycle.
  task automatic fill(input logic [19:0] ra);
    cycle(1, ra, 0, 0);
    cycle(1, ra, 0, 1);
    cycle(1, ra, 0, 0);
  endtask

  initial begin
    int n;
    logic [19:0] ra;
    rst = 1'b1; req_valid_i = 0; req_addr_i = '0; invalidate_i = 0; mem_ready_i = 0; mem_rdata_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    chk("rst resp_valid", {31'b0, resp_valid_o}, 32'd0);
    chk("rst resp_instr", resp_instr_o, 32'd0);
    chk("rst stall", {31'b0, stall_o}, 32'd0);
    chk("rst mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst mem_addr", {12'b0, mem_addr_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First miss, refill, forward, then same-line hit.
    mem[20'h01000] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    cycle(1, 20'h01000, 0, 0);
    chk("t1 miss stall", {31'b0, a_st}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 20'h01000, 0, 0);
      chk("t1 mem_req", {31'b0, a_mr}, 32'd1);
      chk("t1 mem_addr", {12'b0, a_ma}, 32'h01000);
    end
    cycle(1, 20'h01000, 0, 1);
    cycle(1, 20'h01000, 0, 0);
    chk("t1 fill valid", {31'b0, a_rv}, 32'd1);
    chk("t1 fill word", a_in, 32'hAAAAAAAA);
    cycle(1, 20'h0100C, 0, 0);
    chk("t1 hit valid", {31'b0, a_rv}, 32'd1);
    chk("t1 hit word", a_in, 32'hDDDDDDDD);

    // Conflict on index 0.
    cycle(1, 20'h01040, 0, 0);
    chk("t2 conflict stall", {31'b0, a_st}, 32'd1);
    cycle(1, 20'h01040, 0, 1);
    chk("t2 mem_addr", {12'b0, a_ma}, 32'h01040);
    cycle(1, 20'h01040, 0, 0);
    cycle(1, 20'h01000, 0, 0);
    chk("t2 evicted stall", {31'b0, a_st}, 32'd1);
    cycle(1, 20'h01000, 0, 1);
    cycle(1, 20'h01000, 0, 0);

    // Slow memory: 9 idle refill cycles then ready -> 12 cycles miss-to-response.
    n = 1;
    cycle(1, 20'h02008, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cycle(1, 20'h02008, 0, 0);
      n++;
      chk("t3 hold req", {31'b0, a_mr}, 32'd1);
      chk("t3 hold addr", {12'b0, a_ma}, 32'h02000);
      chk("t3 hold stall", {31'b0, a_st}, 32'd1);
    end
    cycle(1, 20'h02008, 0, 1);
    n++;
    for (int i = 0; i < 5 && !a_rv; i++) begin
      cycle(1, 20'h02008, 0, 0);
      n++;
    end
    chk("t3 latency", n, 32'd12);

    // Flash invalidate in lookup state, then invalidate during a refill.
    for (int i = 0; i < 4; i++) fill(20'h00000 + 20'(i * 16));
    cycle(0, 20'h0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      ra = 20'(i * 16);
      cycle(1, ra, 0, 0);
      chk("t4 post-inv miss", {31'b0, a_st}, 32'd1);
      cycle(1, ra, 0, 1);
      cycle(1, ra, 0, 0);
    end
    cycle(1, 20'h00054, 0, 0);
    cycle(1, 20'h00054, 1, 0);
    cycle(1, 20'h00054, 0, 1);
    cycle(1, 20'h00054, 0, 0);
    chk("t4 pend fill valid", {31'b0, a_rv}, 32'd1);
    cycle(1, 20'h00054, 0, 0);
    chk("t4 pend re-miss", {31'b0, a_st}, 32'd1);
    cycle(1, 20'h00054, 0, 1);
    cycle(1, 20'h00054, 0, 0);

    // Asynchronous reset in the middle of a refill.
    cycle(1, 20'h00070, 0, 0);
    cycle(1, 20'h00070, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t5 rst mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("t5 rst stall", {31'b0, stall_o}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 20'h00070, 0, 0);
    chk("t5 re-miss", {31'b0, a_st}, 32'd1);
    cycle(1, 20'h00070, 0, 1);
    cycle(1, 20'h00070, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 20'h00074, 0, 0);
`ifdef ICACHE_PERF_EN
    chk("t6 miss_count", miss_count_o, 32'd1);
    chk("t6 hit_count", hit_count_o, 32'd3);
`endif

    // Random traffic over a small address set to mix hits, conflicts and stray ready pulses.
    for (int c = 0; c < 3000; c++) begin
      bit rv, inv, rdy;
      if (ph == 0) begin
        rv = ($urandom % 8) != 0;
        ra = {14'(64 + $urandom % 3), 2'($urandom % 4), 2'($urandom % 4), 2'($urandom % 4)};
      end else begin
        rv = ($urandom % 12) != 0;
        ra = maddr;
      end
      inv = ($urandom % 25) == 0;
      rdy = (ph == 1) ? (($urandom % 3) == 0) : (($urandom % 6) == 0);
      cycle(rv, ra, inv, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
